mx_int8_bd_decoder: RTL and testbench

//  Block decoder for MXINT8: takes one shared E8M0 scale followed by K int8 elements and emits
//  K FP32 words, one per handshake. Exact inverse path of the FP32->MXINT8 block quantizer.

---
 rtl/mx_int8_bd_decoder_pkg.sv | 28 ++
 rtl/mx_int8_bd_decoder_if.sv | 27 ++
 rtl/mx_int8_bd_decoder_elem.sv | 41 ++++
 rtl/mx_int8_bd_decoder.sv | 95 +++++++++
 tb/tb_mx_int8_bd_decoder.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mx_int8_bd_decoder_pkg.sv
// Shared constants, FSM state type and helpers for the MXINT8 block decoder.
package mx_int8_bd_decoder_pkg;

  localparam int unsigned FLOAT32_WIDTH = 32;
  localparam int unsigned MX_INT8_W     = 8;
  localparam int unsigned E8M0_W        = 8;
  localparam int unsigned FP32_BIAS     = 127;
  localparam int unsigned MXINT8_FRAC   = 6;

  localparam logic [E8M0_W-1:0]        E8M0_NAN  = 8'hFF;
  localparam logic [FLOAT32_WIDTH-1:0] FP32_QNAN = 32'h7FC0_0000;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  // Index of the most significant set bit; 0 when the input is zero.
  function automatic logic [2:0] lead_one(input logic [MX_INT8_W-1:0] m);
    logic [2:0] p;
    p = '0;
    for (int unsigned i = 0; i < MX_INT8_W; i++) begin
      if (m[i]) p = 3'(i);
    end
    return p;
  endfunction

endpackage

// File: rtl/mx_int8_bd_decoder_if.sv
// Scale/element input handshakes and FP32 output handshake of the block decoder.
interface mx_int8_bd_decoder_if;
  import mx_int8_bd_decoder_pkg::*;

  logic [E8M0_W-1:0]        scale_i;
  logic                     scale_valid_i;
  logic                     scale_ready_o;
  logic [MX_INT8_W-1:0]     elem_i;
  logic                     elem_valid_i;
  logic                     elem_ready_o;
  logic [FLOAT32_WIDTH-1:0] gen_float32;
  logic                     data_ready_o;
  logic                     out_ready_i;
  logic                     block_last_o;

  // Producer/consumer side driving the decoder.
  modport master (
    output scale_i, scale_valid_i, elem_i, elem_valid_i, out_ready_i,
    input  scale_ready_o, elem_ready_o, gen_float32, data_ready_o, block_last_o
  );

  // Decoder side.
  modport slave (
    input  scale_i, scale_valid_i, elem_i, elem_valid_i, out_ready_i,
    output scale_ready_o, elem_ready_o, gen_float32, data_ready_o, block_last_o
  );
endinterface

// File: rtl/mx_int8_bd_decoder_elem.sv
// Exact combinational conversion of one int8 (1.6 fixed point) element under an E8M0 scale to FP32.
module mx_int8_elem_to_fp32
  import mx_int8_bd_decoder_pkg::*;
(
  input  logic [E8M0_W-1:0]        scale_i,
  input  logic [MX_INT8_W-1:0]     elem_i,
  output logic [FLOAT32_WIDTH-1:0] fp32_o
);

  logic              sign;
  logic [7:0]        mag;
  logic [2:0]        p;
  logic signed [9:0] exp_s;
  logic [30:0]       norm;
  logic [22:0]       sub;

  // Normalise magnitude and pick NaN / zero / inf / normal / subnormal encoding.
  always_comb begin
    sign  = elem_i[7];
    mag   = sign ? (8'd0 - elem_i) : elem_i;
    p     = lead_one(mag);
    exp_s = signed'({2'b00, scale_i}) + signed'({7'b0, p}) - 10'sd6;
    // Leading one lands on bit 23 and is dropped by taking [22:0].
    norm  = {23'b0, mag} << (5'd23 - {2'b00, p});
    // Only used when exp_s <= 0, i.e. scale_i <= 6, so the shift stays below 23.
    sub   = {15'b0, mag} << (scale_i[4:0] + 5'd16);
    fp32_o = '0;
    if (scale_i == E8M0_NAN) begin
      fp32_o = FP32_QNAN;
    end else if (mag == 8'd0) begin
      fp32_o = '0;
    end else if (exp_s >= 10'sd255) begin
      fp32_o = {sign, 8'hFF, 23'b0};
    end else if (exp_s >= 10'sd1) begin
      fp32_o = {sign, exp_s[7:0], norm[22:0]};
    end else begin
      fp32_o = {sign, 8'h00, sub};
    end
  end

endmodule

// File: rtl/mx_int8_bd_decoder.sv
// MXINT8 block decoder: latches one E8M0 scale, then streams K elements out as FP32 words.
module mx_int8_bd_decoder
  import mx_int8_bd_decoder_pkg::*;
#(
  parameter int unsigned K = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  mx_int8_bd_decoder_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(K);

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [E8M0_W-1:0]        scale_q, scale_d;
  logic [FLOAT32_WIDTH-1:0] out_q, out_d;
  logic                     dv_q, dv_d;
  logic                     last_q, last_d;

  logic                     scale_ready;
  logic                     elem_ready;
  logic [FLOAT32_WIDTH-1:0] conv;

  mx_int8_elem_to_fp32 u_conv (
    .scale_i (scale_q),
    .elem_i  (bus.elem_i),
    .fp32_o  (conv)
  );

  assign bus.scale_ready_o = scale_ready;
  assign bus.elem_ready_o  = elem_ready;
  assign bus.gen_float32   = out_q;
  assign bus.data_ready_o  = dv_q;
  assign bus.block_last_o  = last_q;

  // State register, counter, scale register and 1-deep output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      scale_q <= '0;
      out_q   <= '0;
      dv_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scale_q <= scale_d;
      out_q   <= out_d;
      dv_q    <= dv_d;
      last_q  <= last_d;
    end
  end

  // Next-state, handshake readies and output-register update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    scale_d     = scale_q;
    out_d       = out_q;
    dv_d        = dv_q;
    last_d      = last_q;
    scale_ready = (state_q == IDLE);
    elem_ready  = (state_q == STREAM) && (!dv_q || bus.out_ready_i);

    // A pop with no load empties the register; a load below overrides this.
    if (dv_q && bus.out_ready_i) dv_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.scale_valid_i) begin
          scale_d = bus.scale_i;
          cnt_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (bus.elem_valid_i && elem_ready) begin
          out_d  = conv;
          dv_d   = 1'b1;
          last_d = (cnt_q == CNT_W'(K - 1));
          if (cnt_q == CNT_W'(K - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mx_int8_bd_decoder.sv
// Self-checking bench for the MXINT8 block decoder.
module tb_mx_int8_bd_decoder;
  import mx_int8_bd_decoder_pkg::*;

  localparam int K = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mx_int8_bd_decoder_if bus ();

  mx_int8_bd_decoder #(.K(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  scale;
    logic [7:0]  elem;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [9];
  logic [32:0] expq [$];
  logic [32:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  // Independent reference: shift magnitude up to bit 23, derive biased exponent.
  function automatic logic [31:0] ref_fp(input logic [7:0] x, input logic [7:0] el);
    int          mag, e, k;
    logic [31:0] mant;
    logic        s;
    if (x == 8'hFF) return 32'h7FC0_0000;
    s   = el[7];
    mag = s ? 256 - int'(el) : int'(el);
    if (mag == 0) return 32'h0;
    mant = 32'(mag);
    k    = 0;
    while (mant < 32'h0080_0000) begin
      mant = mant << 1;
      k++;
    end
    e = int'(x) + 17 - k;
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e >= 1) return {s, e[7:0], mant[22:0]};
    mant = mant >> (1 - e);
    return {s, 8'h00, mant[22:0]};
  endfunction

  // Scoreboard: every popped word must match the next expected {last, data}.
  always @(negedge clk) begin
    if (rst_n && bus.data_ready_o && bus.out_ready_i) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%08h required=none", bus.gen_float32);
      end else begin
        mon_e = expq.pop_front();
        chk("data", bus.gen_float32, mon_e[31:0]);
        chk("last", {31'b0, bus.block_last_o}, {31'b0, mon_e[32]});
      end
    end
  end

  task automatic send_scale(input logic [7:0] x);
    bit h;
    int n;
    h = 0;
    n = 0;
    bus.scale_i       = x;
    bus.scale_valid_i = 1'b1;
    while (!h && n < 100) begin
      @(negedge clk);
      h = bus.scale_ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    bus.scale_valid_i = 1'b0;
    if (!h) begin
      checks++;
      errors++;
      $display("FAIL scale_timeout actual=0 required=1");
    end
  endtask

  task automatic send_elem(input logic [7:0] el, input logic [31:0] req, input logic last);
    bit h;
    int n;
    h = 0;
    n = 0;
    bus.elem_i       = el;
    bus.elem_valid_i = 1'b1;
    while (!h && n < 100) begin
      @(negedge clk);
      h = bus.elem_ready_o;
      if (h) expq.push_back({last, req});
      @(posedge clk);
      #1;
      n++;
    end
    bus.elem_valid_i = 1'b0;
    if (!h) begin
      checks++;
      errors++;
      $display("FAIL elem_timeout actual=0 required=1");
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", 32'(expq.size()), 32'd0);
  endtask

  // Holds out_ready_i low for 5 cycles with a word pending.
  task automatic stall5();
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, bus.data_ready_o}, 32'd1);
      chk("stall_elem_ready", {31'b0, bus.elem_ready_o}, 32'd0);
      chk("stall_hold", bus.gen_float32, expq[0][31:0]);
    end
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b1;
  endtask

  initial begin
    logic [7:0] el;
    checks = 0;
    errors = 0;
    vecs[0] = '{8'd127, 8'h40, 32'h3F80_0000};
    vecs[1] = '{8'd127, 8'hC0, 32'hBF80_0000};
    vecs[2] = '{8'd127, 8'h01, 32'h3C80_0000};
    vecs[3] = '{8'd127, 8'h00, 32'h0000_0000};
    vecs[4] = '{8'd254, 8'h7F, 32'h7F7E_0000};
    vecs[5] = '{8'd254, 8'h80, 32'hFF80_0000};
    vecs[6] = '{8'd0,   8'h01, 32'h0001_0000};
    vecs[7] = '{8'd0,   8'hFF, 32'h8001_0000};
    vecs[8] = '{8'd0,   8'h80, 32'h8080_0000};

    rst_n             = 1'b0;
    bus.scale_i       = '0;
    bus.scale_valid_i = 1'b0;
    bus.elem_i        = '0;
    bus.elem_valid_i  = 1'b0;
    bus.out_ready_i   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_data_ready", {31'b0, bus.data_ready_o}, 32'd0);
    chk("rst_gen_float32", bus.gen_float32, 32'd0);
    chk("rst_block_last", {31'b0, bus.block_last_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_scale_ready", {31'b0, bus.scale_ready_o}, 32'd1);
    chk("idle_elem_ready", {31'b0, bus.elem_ready_o}, 32'd0);

    // Element offered in IDLE must not be taken.
    bus.elem_i       = 8'h40;
    bus.elem_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_elem_refused", {31'b0, bus.elem_ready_o}, 32'd0);
      chk("idle_no_output", {31'b0, bus.data_ready_o}, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.elem_valid_i = 1'b0;

    // Directed vectors: each runs as a full block of identical elements.
    for (int v = 0; v < 9; v++) begin
      send_scale(vecs[v].scale);
      for (int i = 0; i < K; i++) send_elem(vecs[v].elem, vecs[v].exp, i == K - 1);
    end
    wait_drain();

    // NaN scale: every element, including zero, decodes to the quiet NaN.
    send_scale(8'hFF);
    for (int i = 0; i < K; i++) begin
      el = (i == 5) ? 8'h00 : 8'($urandom_range(0, 255));
      send_elem(el, 32'h7FC0_0000, i == K - 1);
    end
    wait_drain();

    // Back-to-back blocks with a mid-block stall on the first.
    send_scale(8'd127);
    for (int i = 0; i < K; i++) begin
      el = 8'(i * 37 + 11);
      send_elem(el, ref_fp(8'd127, el), i == K - 1);
      if (i == 9) stall5();
    end
    send_scale(8'd3);
    for (int i = 0; i < K; i++) begin
      el = 8'(i * 53 + 128);
      send_elem(el, ref_fp(8'd3, el), i == K - 1);
    end
    wait_drain();

    // Reset one cycle after the 10th element, with its output still pending.
    send_scale(8'd130);
    for (int i = 0; i < 10; i++) begin
      el = 8'(i * 19 + 1);
      send_elem(el, ref_fp(8'd130, el), 1'b0);
    end
    bus.out_ready_i = 1'b0;
    rst_n           = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expq.delete();
    @(negedge clk);
    chk("midrst_data_ready", {31'b0, bus.data_ready_o}, 32'd0);
    chk("midrst_scale_ready", {31'b0, bus.scale_ready_o}, 32'd1);
    chk("midrst_elem_ready", {31'b0, bus.elem_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b1;
    send_scale(8'd120);
    for (int i = 0; i < K; i++) begin
      el = 8'(255 - i * 7);
      send_elem(el, ref_fp(8'd120, el), i == K - 1);
    end
    wait_drain();
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
